// File: rtl/vote_pkg.sv
// ----------------------------------------------------------------------------
// vote_pkg
// Shared encodings for the voting-session controller: decision-rule codes
// carried on MODE and the session FSM states.
// ----------------------------------------------------------------------------
package vote_pkg;

   // Decision rule applied in TALLY, latched from MODE on an accepted START.
   typedef enum logic [1:0] {
      MODE_ABS  = 2'b00,   // absolute majority of all N voters
      MODE_REL  = 2'b01,   // more yes than no among votes cast
      MODE_UNAN = 2'b10,   // every one of the N voters said yes
      MODE_THR  = 2'b11    // yes count reaches THRESH
   } mode_e;

   // Session phases.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      OPEN   = 2'b01,
      TALLY  = 2'b10,
      RESULT = 2'b11
   } state_e;

endpackage : vote_pkg

// File: rtl/vote_popcount.sv
// ----------------------------------------------------------------------------
// vote_popcount
// Combinational population count of an N-bit vector.
//
// Ports:
//   bits   in  N   vector to count
//   count  out CW  number of set bits, CW = $clog2(N+1)
// ----------------------------------------------------------------------------
module vote_popcount #(
   parameter  int N  = 5,
   localparam int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  bits,
   output logic [CW-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < N; i++) begin
         count = count + CW'(bits[i]);
      end
   end

endmodule : vote_popcount

// File: rtl/vote_session_ctrl.sv
// ----------------------------------------------------------------------------
// vote_session_ctrl
// Runs one voting session: opens a bounded window, latches each voter's
// first vote, tallies yes/no counts and applies the selected decision rule.
//
// Ports:
//   CLK        in  1   system clock, rising edge
//   RST        in  1   synchronous active-high reset
//   START      in  1   open a session (accepted in IDLE and RESULT)
//   ABORT      in  1   cancel the session (honoured in OPEN and TALLY)
//   MODE       in  2   decision rule, latched on the accepted START
//   VOTE_EN    in  N   per-voter vote strobe
//   VOTE_VAL   in  N   per-voter value, 1 = yes
//   BUSY       out 1   high in OPEN and TALLY
//   DONE       out 1   one-cycle pulse on the first RESULT cycle
//   PASS       out 1   decision, held through RESULT
//   YES_CNT    out CW  latched yes votes
//   NO_CNT     out CW  latched no votes
//   VOTED      out N   voters who have voted this session
//   TIME_LEFT  out TW  remaining window cycles
// ----------------------------------------------------------------------------
module vote_session_ctrl
   import vote_pkg::*;
#(
   parameter  int N      = 5,
   parameter  int WINDOW = 16,
   parameter  int THRESH = 3,
   localparam int CW     = $clog2(N + 1),
   localparam int TW     = $clog2(WINDOW + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic          ABORT,
   input  logic [1:0]    MODE,
   input  logic [N-1:0]  VOTE_EN,
   input  logic [N-1:0]  VOTE_VAL,
   output logic          BUSY,
   output logic          DONE,
   output logic          PASS,
   output logic [CW-1:0] YES_CNT,
   output logic [CW-1:0] NO_CNT,
   output logic [N-1:0]  VOTED,
   output logic [TW-1:0] TIME_LEFT
);

   state_e        state, state_next;
   mode_e         mode_r;
   logic [N-1:0]  voted, yes_mask;
   logic [CW-1:0] yes_cnt, no_cnt;
   logic [TW-1:0] time_left;
   logic          pass, done;

   // Control strobes from the FSM to the datapath.
   logic start_sess, abort_sess, take_votes, do_tally;

   // Vote acceptance: only a voter's first strobe in the session is kept.
   logic [N-1:0]  new_votes, voted_upd, yes_upd;
   logic          all_voted;

   assign new_votes = VOTE_EN & ~voted;
   assign voted_upd = voted | VOTE_EN;
   assign yes_upd   = yes_mask | (VOTE_VAL & new_votes);
   assign all_voted = &voted_upd;

   // Tally inputs; yes_mask is cleared per session, so masking with voted
   // only documents that non-voters count as neither yes nor no.
   logic [N-1:0]  yes_bits, no_bits;
   logic [CW-1:0] yes_c, no_c;
   logic          pass_c;

   assign yes_bits = yes_mask & voted;
   assign no_bits  = ~yes_mask & voted;

   vote_popcount #(.N(N)) u_yes_count (
      .bits  (yes_bits),
      .count (yes_c)
   );

   vote_popcount #(.N(N)) u_no_count (
      .bits  (no_bits),
      .count (no_c)
   );

   // Absolute and unanimous rules compare against N, not votes cast.
   // The doubled yes count is one bit wider so it cannot overflow.
   always_comb begin
      pass_c = 1'b0;
      case (mode_r)
         MODE_ABS:  pass_c = {yes_c, 1'b0} > (CW + 1)'(N);
         MODE_REL:  pass_c = yes_c > no_c;
         MODE_UNAN: pass_c = yes_c == CW'(N);
         MODE_THR:  pass_c = yes_c >= CW'(THRESH);
         default:   pass_c = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_next;
   end

   // ---------------------------------------------------------------------
   // FSM next-state and control decode
   // ---------------------------------------------------------------------
   // NOTE: every output of this block gets a default first so no path
   // leaves a signal unassigned and infers a latch.
   always_comb begin
      state_next = state;
      start_sess = 1'b0;
      abort_sess = 1'b0;
      take_votes = 1'b0;
      do_tally   = 1'b0;
      case (state)
         IDLE, RESULT: begin
            // ABORT is meaningless here, so START always wins.
            if (START) begin
               start_sess = 1'b1;
               state_next = OPEN;
            end
         end
         OPEN: begin
            if (ABORT) begin
               abort_sess = 1'b1;
               state_next = IDLE;
            end else begin
               // Votes on the final window cycle are still taken.
               take_votes = 1'b1;
               if (time_left == TW'(1) || all_voted) state_next = TALLY;
            end
         end
         TALLY: begin
            if (ABORT) begin
               abort_sess = 1'b1;
               state_next = IDLE;
            end else begin
               do_tally   = 1'b1;
               state_next = RESULT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: vote latches, window timer, result registers
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         mode_r    <= MODE_ABS;
         voted     <= '0;
         yes_mask  <= '0;
         yes_cnt   <= '0;
         no_cnt    <= '0;
         pass      <= 1'b0;
         done      <= 1'b0;
         time_left <= '0;
      end else begin
         done <= 1'b0;
         if (start_sess) begin
            mode_r    <= mode_e'(MODE);
            voted     <= '0;
            yes_mask  <= '0;
            yes_cnt   <= '0;
            no_cnt    <= '0;
            pass      <= 1'b0;
            time_left <= TW'(WINDOW);
         end else if (abort_sess) begin
            voted     <= '0;
            yes_mask  <= '0;
            yes_cnt   <= '0;
            no_cnt    <= '0;
            pass      <= 1'b0;
            time_left <= '0;
         end else if (take_votes) begin
            voted     <= voted_upd;
            yes_mask  <= yes_upd;
            time_left <= time_left - TW'(1);
         end else if (do_tally) begin
            yes_cnt <= yes_c;
            no_cnt  <= no_c;
            pass    <= pass_c;
            done    <= 1'b1;
         end
      end
   end

   assign BUSY      = (state == OPEN) || (state == TALLY);
   assign DONE      = done;
   assign PASS      = pass;
   assign YES_CNT   = yes_cnt;
   assign NO_CNT    = no_cnt;
   assign VOTED     = voted;
   assign TIME_LEFT = time_left;

endmodule : vote_session_ctrl

// File: tb/tb_vote_session_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vote_session_ctrl
// Directed bench for vote_session_ctrl with default parameters
// (N=5, WINDOW=16, THRESH=3). Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_vote_session_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       START = 1'b0;
   logic       ABORT = 1'b0;
   logic [1:0] MODE = 2'b00;
   logic [4:0] VOTE_EN = '0;
   logic [4:0] VOTE_VAL = '0;
   logic       BUSY, DONE, PASS;
   logic [2:0] YES_CNT, NO_CNT;
   logic [4:0] VOTED;
   logic [4:0] TIME_LEFT;

   int checks = 0;
   int errors = 0;

   vote_session_ctrl #(.N(5), .WINDOW(16), .THRESH(3)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .START     (START),
      .ABORT     (ABORT),
      .MODE      (MODE),
      .VOTE_EN   (VOTE_EN),
      .VOTE_VAL  (VOTE_VAL),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .PASS      (PASS),
      .YES_CNT   (YES_CNT),
      .NO_CNT    (NO_CNT),
      .VOTED     (VOTED),
      .TIME_LEFT (TIME_LEFT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no end of run, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
         $error("check %s differs", tag);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic quiet();
      START    = 1'b0;
      ABORT    = 1'b0;
      VOTE_EN  = '0;
      VOTE_VAL = '0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"},  BUSY, 0);
      check({tag, "_done"},  DONE, 0);
      check({tag, "_pass"},  PASS, 0);
      check({tag, "_yes"},   YES_CNT, 0);
      check({tag, "_no"},    NO_CNT, 0);
      check({tag, "_voted"}, VOTED, 0);
      check({tag, "_tl"},    TIME_LEFT, 0);
   endtask

   // Steps until DONE rises or the budget runs out; a timeout is a failed check.
   task automatic wait_done(input int budget, output int cycles);
      cycles = 0;
      while (DONE !== 1'b1 && cycles < budget) begin
         step();
         cycles++;
      end
      check("done_seen", DONE, 1);
   endtask

   // Voter 0 yes, then voter 0 strobes no together with voter 1 yes,
   // then voter 2 yes; the window then runs out.
   task automatic run_repeat_vote(input logic [1:0] mode, input logic exp_pass,
                                  input string tag);
      int cyc;
      MODE = mode; START = 1'b1;
      step();
      quiet();
      VOTE_EN = 5'b00001; VOTE_VAL = 5'b00001; step();
      VOTE_EN = 5'b00011; VOTE_VAL = 5'b00010; step();
      VOTE_EN = 5'b00100; VOTE_VAL = 5'b00100; step();
      quiet();
      check({tag, "_tl"}, TIME_LEFT, 13);
      // 13 remaining OPEN cycles plus one TALLY cycle.
      wait_done(40, cyc);
      check({tag, "_latency"}, cyc, 14);
      check({tag, "_yes"},  YES_CNT, 3);
      check({tag, "_no"},   NO_CNT, 0);
      check({tag, "_pass"}, PASS, exp_pass);
   endtask

   initial begin
      int cyc;

      // ---------------- reset ----------------
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      check_reset_values("rst");

      // Strobes in IDLE are ignored.
      VOTE_EN = 5'b11111; VOTE_VAL = 5'b11111;
      step();
      quiet();
      check("idle_vote_voted", VOTED, 0);
      check("idle_vote_busy",  BUSY, 0);

      // ---------------- A: early close, absolute majority ----------------
      MODE = 2'b00; START = 1'b1;
      step();
      quiet();
      check("a_open_busy", BUSY, 1);
      check("a_open_tl",   TIME_LEFT, 16);
      VOTE_EN = 5'b11111; VOTE_VAL = 5'b00011;
      step();
      quiet();
      check("a_tally_voted", VOTED, 5'b11111);
      check("a_tally_tl",    TIME_LEFT, 15);
      check("a_tally_busy",  BUSY, 1);
      check("a_tally_done",  DONE, 0);
      step();
      check("a_done",   DONE, 1);
      check("a_yes",    YES_CNT, 2);
      check("a_no",     NO_CNT, 3);
      check("a_pass",   PASS, 0);
      check("a_busy",   BUSY, 0);
      check("a_tl",     TIME_LEFT, 15);
      VOTE_EN = 5'b11111; VOTE_VAL = 5'b11111;
      step();
      quiet();
      check("a_done_pulse", DONE, 0);
      check("a_hold_yes",   YES_CNT, 2);
      check("a_result_vote_voted", VOTED, 5'b11111);

      // ---------------- B: relative majority, full window ----------------
      MODE = 2'b01; START = 1'b1;
      step();
      quiet();
      check("b_restart_yes",   YES_CNT, 0);
      check("b_restart_no",    NO_CNT, 0);
      check("b_restart_voted", VOTED, 0);
      check("b_restart_tl",    TIME_LEFT, 16);
      for (int i = 0; i < 16; i++) begin
         VOTE_EN = '0; VOTE_VAL = '0;
         if (i == 0) begin VOTE_EN = 5'b00001; VOTE_VAL = 5'b00001; end
         if (i == 3) begin VOTE_EN = 5'b00010; VOTE_VAL = 5'b00010; end
         if (i == 6) begin VOTE_EN = 5'b00100; VOTE_VAL = 5'b00000; end
         step();
         if (i == 14) check("b_tl_last", TIME_LEFT, 1);
      end
      quiet();
      check("b_tally_tl",   TIME_LEFT, 0);
      check("b_tally_busy", BUSY, 1);
      check("b_tally_done", DONE, 0);
      step();
      check("b_done",  DONE, 1);
      check("b_yes",   YES_CNT, 2);
      check("b_no",    NO_CNT, 1);
      check("b_pass",  PASS, 1);
      check("b_voted", VOTED, 5'b00111);

      // ---------------- C: first vote stands ----------------
      run_repeat_vote(2'b00, 1'b1, "c_abs");
      run_repeat_vote(2'b10, 1'b0, "c_unan");

      // ---------------- D: threshold, vote on final cycle ----------------
      MODE = 2'b11; START = 1'b1;
      step();
      quiet();
      VOTE_EN = 5'b00001; VOTE_VAL = 5'b00001; step();
      VOTE_EN = 5'b00010; VOTE_VAL = 5'b00010; step();
      quiet();
      for (int i = 0; i < 13; i++) step();
      check("d_tl_one", TIME_LEFT, 1);
      check("d_busy",   BUSY, 1);
      VOTE_EN = 5'b10000; VOTE_VAL = 5'b10000;
      step();
      quiet();
      check("d_tally_tl",    TIME_LEFT, 0);
      check("d_tally_voted", VOTED, 5'b10011);
      step();
      check("d_done", DONE, 1);
      check("d_yes",  YES_CNT, 3);
      check("d_no",   NO_CNT, 0);
      check("d_pass", PASS, 1);

      // ---------------- E: abort and mid-window reset ----------------
      MODE = 2'b00; START = 1'b1;
      step();
      quiet();
      VOTE_EN = 5'b00011; VOTE_VAL = 5'b00001;
      step();
      quiet();
      check("e_voted_before", VOTED, 5'b00011);
      START = 1'b1; ABORT = 1'b1;
      step();
      quiet();
      check("e_abort_busy",  BUSY, 0);
      check("e_abort_voted", VOTED, 0);
      check("e_abort_pass",  PASS, 0);
      check("e_abort_tl",    TIME_LEFT, 0);
      check("e_abort_done",  DONE, 0);
      step();
      check("e_abort_done2", DONE, 0);
      check("e_abort_idle",  BUSY, 0);

      // START beats ABORT in IDLE.
      START = 1'b1; ABORT = 1'b1;
      step();
      quiet();
      check("e_start_wins_busy", BUSY, 1);
      check("e_start_wins_tl",   TIME_LEFT, 16);
      VOTE_EN = 5'b00011; VOTE_VAL = 5'b00011;
      step();
      quiet();
      check("e_mid_voted", VOTED, 5'b00011);
      RST = 1'b1; START = 1'b1;
      step();
      RST = 1'b0;
      quiet();
      check_reset_values("e_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_vote_session_ctrl
